// File: rtl/fp2int.sv
`default_nettype none
// ============================================================================
// Module      : fp2int
// Description : Iterative IEEE 754 single-precision to signed 32-bit integer
//               converter. Truncates toward zero; saturates on overflow/Inf
//               and NaN, raising ovf / invalid. One alignment shift per cycle.
// Revision    : 1.0  initial release
// ============================================================================
module fp2int (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        ovf,
  output logic        invalid
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CLASSIFY = 3'd1;
  localparam logic [2:0] SHIFT    = 3'd2;
  localparam logic [2:0] SIGN     = 3'd3;
  localparam logic [2:0] FINISH   = 3'd4;

  localparam logic [31:0] POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_SAT = 32'h8000_0000;
  localparam logic [31:0] MIN_INT = 32'hCF00_0000;  // exactly -2^31 as a float

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [31:0] a_reg;
  logic [31:0] mag;
  logic [4:0]  count;
  logic        dir_left;

  // Field decode of the latched operand
  logic        sign;
  logic [7:0]  exp;
  logic [22:0] frac;
  logic        is_nan;
  logic        is_inf;
  logic        is_min;
  logic        is_big;
  logic        is_small;
  logic        special;
  logic        shl;
  logic [4:0]  shift_k;

  assign sign     = a_reg[31];
  assign exp      = a_reg[30:23];
  assign frac     = a_reg[22:0];
  assign is_nan   = (exp == 8'd255) && (frac != 23'd0);
  assign is_inf   = (exp == 8'd255) && (frac == 23'd0);
  assign is_min   = (a_reg == MIN_INT);
  assign is_big   = (exp >= 8'd158);                 // e >= 31
  assign is_small = (exp <  8'd127);                 // e < 0
  assign special  = is_nan | is_inf | is_min | is_big | is_small;
  assign shl      = (exp >= 8'd150);                 // e >= 23

  // On the normal path |e-23| <= 23, so modulo-32 arithmetic on the low
  // exponent bits gives the exact shift count (150 mod 32 = 22).
  assign shift_k  = shl ? (exp[4:0] - 5'd22) : (5'd22 - exp[4:0]);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = CLASSIFY;
      CLASSIFY: begin
        if (special)              next_state = FINISH;
        else if (shift_k != 5'd0) next_state = SHIFT;
        else                      next_state = SIGN;
      end
      SHIFT:    if (count == 5'd1) next_state = SIGN;
      SIGN:     next_state = FINISH;
      FINISH:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Status outputs are pure functions of the state so reset clears them at once
  always_comb begin
    done = (state == FINISH);
    busy = (state != IDLE);
  end

  // Operand capture, classification, alignment loop and sign application
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg    <= 32'd0;
      mag      <= 32'd0;
      count    <= 5'd0;
      dir_left <= 1'b0;
      result   <= 32'd0;
      ovf      <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) a_reg <= a;
        end
        CLASSIFY: begin
          if (is_nan) begin
            result  <= NEG_SAT;
            invalid <= 1'b1;
            ovf     <= 1'b0;
          end else if (is_inf) begin
            result  <= sign ? NEG_SAT : POS_SAT;
            ovf     <= 1'b1;
            invalid <= 1'b0;
          end else if (is_min) begin
            result  <= NEG_SAT;
            ovf     <= 1'b0;
            invalid <= 1'b0;
          end else if (is_big) begin
            result  <= sign ? NEG_SAT : POS_SAT;
            ovf     <= 1'b1;
            invalid <= 1'b0;
          end else if (is_small) begin
            result  <= 32'd0;
            ovf     <= 1'b0;
            invalid <= 1'b0;
          end else begin
            mag      <= {8'd0, 1'b1, frac};
            count    <= shift_k;
            dir_left <= shl;
            ovf      <= 1'b0;
            invalid  <= 1'b0;
          end
        end
        SHIFT: begin
          mag   <= dir_left ? (mag << 1) : (mag >> 1);
          count <= count - 5'd1;
        end
        SIGN: begin
          // Left shift is capped at 7, so mag < 2^31 and negation is exact
          result <= sign ? (~mag + 32'd1) : mag;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp2int.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp2int
// Description : Self-checking bench for fp2int: directed cases, randomized
//               operands against a value-based reference model, busy-start
//               rejection, back-to-back throughput and reset abort.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fp2int;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        ovf;
  logic        invalid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fp2int dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .result  (result),
    .done    (done),
    .busy    (busy),
    .ovf     (ovf),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  // Free-running clock
  always #5 clk = ~clk;

  // Reference: real value of the float, truncated, then range-checked
  function automatic void ref_conv(input logic [31:0] x, output logic [31:0] r,
                                   output logic o, output logic iv, output int lat);
    int     e;
    longint m;
    longint v;
    e  = int'(x[30:23]) - 127;
    m  = longint'(x[22:0]) + 64'sd8388608;
    o  = 1'b0;
    iv = 1'b0;
    if (x[30:23] == 8'd255) begin
      lat = 2;
      if (x[22:0] != 23'd0) begin r = 32'h8000_0000; iv = 1'b1; end
      else begin r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; o = 1'b1; end
      return;
    end
    if (e < 0) begin r = 32'd0; lat = 2; return; end
    if (e >= 40)      v = 64'sd1 << 40;
    else if (e >= 23) v = m << (e - 23);
    else              v = m >> (23 - e);
    if (x[31]) v = -v;
    if (v > 64'sd2147483647) begin
      r = 32'h7FFF_FFFF; o = 1'b1;
    end else if (v < -64'sd2147483648) begin
      r = 32'h8000_0000; o = 1'b1;
    end else begin
      r = v[31:0];
    end
    lat = (e >= 31) ? 2 : 3 + ((e >= 23) ? (e - 23) : (23 - e));
  endfunction

  // Launch one conversion and report what came out and when (-1 = no done)
  task automatic run_op(input logic [31:0] x, output logic [31:0] r,
                        output logic o, output logic iv, output int lat);
    r   = 32'hDEAD_BEEF;
    o   = 1'bx;
    iv  = 1'bx;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    a     = x;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        r   = result;
        o   = ovf;
        iv  = invalid;
        lat = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    total_cnt++; if (result !== 32'd0) $display("FAIL reset_result got %h want 0", result); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else pass_cnt++;
    total_cnt++; if (invalid !== 1'b0) $display("FAIL reset_invalid got %b want 0", invalid); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] va [13] = '{32'h3F80_0000, 32'hC2F6_E666, 32'h4B00_0001, 32'h4EFF_FFFF,
                             32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000,
                             32'h8000_0000, 32'h0000_0001, 32'h3F7F_FFFF, 32'h7F80_0000,
                             32'hCF00_0001};
    logic [31:0] vr [13] = '{32'h0000_0001, 32'hFFFF_FF85, 32'h0080_0001, 32'h7FFF_FF80,
                             32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                             32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF,
                             32'h8000_0000};
    logic        vo [13] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1};
    logic        vi [13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int          vl [13] = '{26, 20, 3, 10, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    logic [31:0] r;
    logic        o, iv;
    int          lat;
    for (int i = 0; i < 13; i++) begin
      run_op(va[i], r, o, iv, lat);
      total_cnt++; if (r !== vr[i]) $display("FAIL dir_result a=%h got %h want %h", va[i], r, vr[i]); else pass_cnt++;
      total_cnt++; if (o !== vo[i]) $display("FAIL dir_ovf a=%h got %b want %b", va[i], o, vo[i]); else pass_cnt++;
      total_cnt++; if (iv !== vi[i]) $display("FAIL dir_invalid a=%h got %b want %b", va[i], iv, vi[i]); else pass_cnt++;
      total_cnt++; if (lat != vl[i]) $display("FAIL dir_latency a=%h got %0d want %0d", va[i], lat, vl[i]); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (done !== 1'b0) $display("FAIL dir_done_width a=%h got done=%b want 0", va[i], done); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [31:0] x, r, er;
    logic        o, iv, eo, eiv;
    int          lat, elat;
    for (int i = 0; i < 60; i++) begin
      if (i % 4 == 3) x = $urandom;
      else x = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 162)), 23'($urandom)};
      ref_conv(x, er, eo, eiv, elat);
      run_op(x, r, o, iv, lat);
      total_cnt++; if (r !== er) $display("FAIL rnd_result a=%h got %h want %h", x, r, er); else pass_cnt++;
      total_cnt++; if (o !== eo || iv !== eiv) $display("FAIL rnd_flags a=%h got ovf=%b inv=%b want ovf=%b inv=%b", x, o, iv, eo, eiv); else pass_cnt++;
      total_cnt++; if (lat != elat) $display("FAIL rnd_latency a=%h got %0d want %0d", x, lat, elat); else pass_cnt++;
    end
  endtask

  task automatic test_busy_ignore();
    int          dones = 0;
    logic [31:0] res = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b1;
    a     = 32'h3F80_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL busy_mid got %b want 1", busy); else pass_cnt++;
    start = 1'b1;
    a     = 32'h4B00_0001;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin dones++; res = result; end
    end
    total_cnt++; if (dones != 1) $display("FAIL busy_done_count got %0d want 1", dones); else pass_cnt++;
    total_cnt++; if (res !== 32'd1) $display("FAIL busy_result got %h want 00000001", res); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [2] = '{32'h4B00_0001, 32'h7FC0_0000};
    logic [31:0] rs [2] = '{32'h0080_0001, 32'h8000_0000};
    int          gap[2] = '{4, 3};
    int          q[$];
    for (int t = 0; t < 2; t++) begin
      q.delete();
      @(negedge clk);
      start = 1'b1;
      a     = xs[t];
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) begin
          q.push_back(i);
          total_cnt++; if (result !== rs[t]) $display("FAIL b2b_result got %h want %h", result, rs[t]); else pass_cnt++;
        end
      end
      start = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (!busy) break;
      end
      repeat (2) @(negedge clk);
      total_cnt++; if (q.size() < 5) $display("FAIL b2b_count got %0d want >=5", q.size()); else pass_cnt++;
      for (int j = 1; j < q.size() && j < 5; j++) begin
        total_cnt++;
        if (q[j] - q[j-1] != gap[t]) $display("FAIL b2b_gap got %0d want %0d", q[j] - q[j-1], gap[t]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    logic        o, iv;
    int          lat;
    int          dones = 0;
    run_op(32'h4F00_0000, r, o, iv, lat);
    @(negedge clk);
    start = 1'b1;
    a     = 32'h3F80_0000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    total_cnt++; if (result !== 32'd0) $display("FAIL abort_result got %h want 0", result); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0 || ovf !== 1'b0 || invalid !== 1'b0)
      $display("FAIL abort_flags got done=%b ovf=%b inv=%b want 0", done, ovf, invalid); else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    total_cnt++; if (dones != 0) $display("FAIL abort_no_done got %0d want 0", dones); else pass_cnt++;
    run_op(32'h3F80_0000, r, o, iv, lat);
    total_cnt++; if (r !== 32'd1) $display("FAIL abort_after_result got %h want 00000001", r); else pass_cnt++;
    total_cnt++; if (lat != 26) $display("FAIL abort_after_latency got %0d want 26", lat); else pass_cnt++;
  endtask

  // Test sequence
  initial begin
    reset = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
